// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants, rectangle descriptor and arbiter state type
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int P_WIDTH  = 12;
    localparam int P_HEIGHT = 12;

    localparam logic [3:0] DIR_UP    = 4'd8;
    localparam logic [3:0] DIR_DOWN  = 4'd4;
    localparam logic [3:0] DIR_RIGHT = 4'd2;
    localparam logic [3:0] DIR_LEFT  = 4'd1;

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic [9:0] width;
        logic [9:0] height;
        logic [3:0] color;
        logic       visible;
    } rect_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DECIDE
    } arb_state_t;

endpackage

// File: rtl/rect_overlap_check.sv
// rtl/rect_overlap_check.sv - strict box overlap plus colour-mismatch test for one rectangle slot
module rect_overlap_check #(
    parameter int P_WIDTH  = 12,
    parameter int P_HEIGHT = 12
) (
    input  logic [9:0] ph,
    input  logic [9:0] pv,
    input  logic [3:0] pcolor,
    input  logic [9:0] rhpos,
    input  logic [9:0] rvpos,
    input  logic [9:0] rwidth,
    input  logic [9:0] rheight,
    input  logic [3:0] rcolor,
    input  logic       rvisible,
    output logic       hit
);

    logic [10:0] r_right;
    logic [10:0] r_bottom;
    logic [10:0] p_right;
    logic [10:0] p_bottom;
    logic        h_overlap;
    logic        v_overlap;

    // Sums are 11 bits so a rectangle near the 10-bit limit never wraps around.
    assign r_right   = {1'b0, rhpos} + {1'b0, rwidth};
    assign r_bottom  = {1'b0, rvpos} + {1'b0, rheight};
    assign p_right   = {1'b0, ph} + 11'(P_WIDTH);
    assign p_bottom  = {1'b0, pv} + 11'(P_HEIGHT);

    assign h_overlap = ({1'b0, ph} < r_right) && (p_right > {1'b0, rhpos});
    assign v_overlap = ({1'b0, pv} < r_bottom) && (p_bottom > {1'b0, rvpos});

    assign hit = rvisible && (rcolor != pcolor) && h_overlap && v_overlap;

endmodule

// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - sequences one shared collision checker over the rectangle table per player move
module move_arbiter
    import game_pkg::*;
#(
    parameter int N_RECT    = 8,
    parameter int IDX_W     = 3,
    parameter int P_WIDTH   = game_pkg::P_WIDTH,
    parameter int P_HEIGHT  = game_pkg::P_HEIGHT,
    parameter int SCREEN_W  = game_pkg::SCREEN_W,
    parameter int SCREEN_H  = game_pkg::SCREEN_H,
    parameter int PLAYER_H0 = 314,
    parameter int PLAYER_V0 = 234
) (
    input  logic             btnClk,
    input  logic             rst_n,
    input  logic [3:0]       btns,
    input  logic [3:0]       player_color,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [9:0]       cfg_hpos,
    input  logic [9:0]       cfg_vpos,
    input  logic [9:0]       cfg_width,
    input  logic [9:0]       cfg_height,
    input  logic [3:0]       cfg_color,
    input  logic             cfg_visible,
    output logic [9:0]       player_hPos,
    output logic [9:0]       player_vPos,
    output logic             busy,
    output logic             move_done,
    output logic             blocked,
    output logic [IDX_W-1:0] hit_idx
);

    localparam logic [9:0] H_MAX = 10'(SCREEN_W - P_WIDTH);
    localparam logic [9:0] V_MAX = 10'(SCREEN_H - P_HEIGHT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RECT - 1);

    arb_state_t       state;
    arb_state_t       next_state;
    rect_t            tbl [N_RECT];
    rect_t            cur_rect;
    logic [IDX_W-1:0] idx;
    logic [3:0]       lat_color;
    logic [9:0]       prop_h;
    logic [9:0]       prop_v;
    logic [9:0]       step_h;
    logic [9:0]       step_v;
    logic             hit_any;
    logic             slot_hit;
    logic             req_ok;

    assign req_ok = (btns == DIR_UP) || (btns == DIR_DOWN) ||
                    (btns == DIR_RIGHT) || (btns == DIR_LEFT);

    always_comb begin
        step_h = player_hPos;
        step_v = player_vPos;
        case (btns)
            DIR_UP:    step_v = (player_vPos == 10'd0) ? V_MAX : player_vPos - 10'd1;
            DIR_DOWN:  step_v = (player_vPos == V_MAX) ? 10'd0 : player_vPos + 10'd1;
            DIR_LEFT:  step_h = (player_hPos == 10'd0) ? H_MAX : player_hPos - 10'd1;
            DIR_RIGHT: step_h = (player_hPos == H_MAX) ? 10'd0 : player_hPos + 10'd1;
            default: ;
        endcase
    end

    // Table read is combinational, so a same-edge write to the scanned slot is not observed.
    always_ff @(posedge btnClk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RECT; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl[cfg_idx] <= '{hpos: cfg_hpos, vpos: cfg_vpos, width: cfg_width,
                              height: cfg_height, color: cfg_color, visible: cfg_visible};
        end
    end

    assign cur_rect = tbl[idx];

    rect_overlap_check #(
        .P_WIDTH (P_WIDTH),
        .P_HEIGHT(P_HEIGHT)
    ) u_check (
        .ph      (prop_h),
        .pv      (prop_v),
        .pcolor  (lat_color),
        .rhpos   (cur_rect.hpos),
        .rvpos   (cur_rect.vpos),
        .rwidth  (cur_rect.width),
        .rheight (cur_rect.height),
        .rcolor  (cur_rect.color),
        .rvisible(cur_rect.visible),
        .hit     (slot_hit)
    );

    always_ff @(posedge btnClk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (req_ok) next_state = ST_SCAN;
            ST_SCAN:   if (idx == LAST_IDX) next_state = ST_DECIDE;
            ST_DECIDE: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // busy also covers the cycle the decision pulse is visible.
    always_comb begin
        busy = (state != ST_IDLE) || move_done || blocked;
    end

    always_ff @(posedge btnClk) begin
        if (!rst_n) begin
            player_hPos <= 10'(PLAYER_H0);
            player_vPos <= 10'(PLAYER_V0);
            move_done   <= 1'b0;
            blocked     <= 1'b0;
            hit_idx     <= '0;
            idx         <= '0;
            hit_any     <= 1'b0;
            lat_color   <= '0;
            prop_h      <= '0;
            prop_v      <= '0;
        end else begin
            move_done <= 1'b0;
            blocked   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        lat_color <= player_color;
                        prop_h    <= step_h;
                        prop_v    <= step_v;
                        idx       <= '0;
                        hit_any   <= 1'b0;
                        hit_idx   <= '0;
                    end
                end
                ST_SCAN: begin
                    idx <= idx + 1'b1;
                    if (slot_hit) begin
                        hit_any <= 1'b1;
                        if (!hit_any) hit_idx <= idx;
                    end
                end
                ST_DECIDE: begin
                    if (hit_any) begin
                        blocked <= 1'b1;
                    end else begin
                        player_hPos <= prop_h;
                        player_vPos <= prop_v;
                        move_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_arbiter.sv
// tb/tb_move_arbiter.sv - directed and randomized checks of move_arbiter against a table-level model
module tb_move_arbiter;

    logic       btnClk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btns = '0;
    logic [3:0] player_color = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [9:0] cfg_hpos = '0, cfg_vpos = '0, cfg_width = '0, cfg_height = '0;
    logic [3:0] cfg_color = '0;
    logic       cfg_visible = 1'b0;
    logic [9:0] player_hPos, player_vPos;
    logic       busy, move_done, blocked;
    logic [2:0] hit_idx;

    int vectors = 0;
    int miscompares = 0;

    int m_h [8], m_v [8], m_w [8], m_ht [8], m_c [8];
    bit m_vis [8];
    int ph, pv;

    move_arbiter dut (
        .btnClk(btnClk), .rst_n(rst_n), .btns(btns), .player_color(player_color),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_hpos(cfg_hpos), .cfg_vpos(cfg_vpos),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_color(cfg_color),
        .cfg_visible(cfg_visible), .player_hPos(player_hPos), .player_vPos(player_vPos),
        .busy(busy), .move_done(move_done), .blocked(blocked), .hit_idx(hit_idx)
    );

    always #5 btnClk = ~btnClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(input int h, input int v, input int col, input int rh,
                                    input int rv, input int rw, input int rht, input int rc,
                                    input bit vis);
        return vis && (rc != col) && (h < rh + rw) && (h + 12 > rh) && (v < rv + rht) && (v + 12 > rv);
    endfunction

    function automatic bit one_hot_dir(input logic [3:0] b);
        return (b == 4'd8) || (b == 4'd4) || (b == 4'd2) || (b == 4'd1);
    endfunction

    task automatic model_step(input logic [3:0] b, input int h, input int v, output int nh, output int nv);
        nh = h;
        nv = v;
        if (b == 4'd8) nv = (v == 0) ? 468 : v - 1;
        if (b == 4'd4) nv = (v == 468) ? 0 : v + 1;
        if (b == 4'd1) nh = (h == 0) ? 628 : h - 1;
        if (b == 4'd2) nh = (h == 628) ? 0 : h + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge btnClk); #1;
        rst_n = 1'b1;
        ph = 314;
        pv = 234;
        for (int i = 0; i < 8; i++) begin
            m_vis[i] = 0; m_h[i] = 0; m_v[i] = 0; m_w[i] = 0; m_ht[i] = 0; m_c[i] = 0;
        end
    endtask

    task automatic drive_cfg(input int s, input int h, input int v, input int w, input int ht,
                             input int c, input bit vis);
        cfg_idx = 3'(s); cfg_hpos = 10'(h); cfg_vpos = 10'(v); cfg_width = 10'(w);
        cfg_height = 10'(ht); cfg_color = 4'(c); cfg_visible = vis; cfg_we = 1'b1;
    endtask

    task automatic write_cfg(input int s, input int h, input int v, input int w, input int ht,
                             input int c, input bit vis);
        drive_cfg(s, h, v, w, ht, c, vis);
        @(posedge btnClk); #1;
        cfg_we = 1'b0;
        m_h[s] = h; m_v[s] = v; m_w[s] = w; m_ht[s] = ht; m_c[s] = c; m_vis[s] = vis;
    endtask

    // A write issued during scan cycle wk lands after slot wk is read, so only slots above wk see it.
    task automatic do_move(input logic [3:0] b, input logic [3:0] col, input bit wen, input int wk,
                           input int ws, input int wh, input int wv, input int ww, input int wht,
                           input int wc, input bit wvis);
        int nh, nv, hit, rh, rv, rw, rht, rc;
        bit rvis, early, idle_gap;
        if (!one_hot_dir(b)) begin
            early = 0;
            btns = b; player_color = col;
            for (int k = 0; k < 3; k++) begin
                @(posedge btnClk); #1;
                btns = '0;
                if (busy || move_done || blocked) early = 1;
            end
            check("ignored_req_quiet", 32'(early), 0);
            check("ignored_req_h", 32'(player_hPos), 32'(ph));
            check("ignored_req_v", 32'(player_vPos), 32'(pv));
            return;
        end
        model_step(b, ph, pv, nh, nv);
        hit = -1;
        for (int i = 7; i >= 0; i--) begin
            rh = m_h[i]; rv = m_v[i]; rw = m_w[i]; rht = m_ht[i]; rc = m_c[i]; rvis = m_vis[i];
            if (wen && i == ws && i > wk) begin
                rh = wh; rv = wv; rw = ww; rht = wht; rc = wc; rvis = wvis;
            end
            if (overlaps(nh, nv, int'(col), rh, rv, rw, rht, rc, rvis)) hit = i;
        end
        btns = b; player_color = col;
        @(posedge btnClk); #1;
        btns = 4'($urandom_range(15));
        player_color = 4'($urandom_range(15));
        early = 0;
        idle_gap = 0;
        for (int k = 0; k < 9; k++) begin
            if (wen && k == wk) drive_cfg(ws, wh, wv, ww, wht, wc, wvis);
            @(posedge btnClk); #1;
            cfg_we = 1'b0;
            if (k < 8) begin
                if (move_done || blocked) early = 1;
                if (!busy) idle_gap = 1;
            end
        end
        btns = '0;
        if (wen) begin
            m_h[ws] = wh; m_v[ws] = wv; m_w[ws] = ww; m_ht[ws] = wht; m_c[ws] = wc; m_vis[ws] = wvis;
        end
        check("no_early_pulse", 32'(early), 0);
        check("busy_during_scan", 32'(idle_gap), 0);
        check("busy_at_decision", 32'(busy), 1);
        check("move_done", 32'(move_done), 32'(hit < 0));
        check("blocked", 32'(blocked), 32'(hit >= 0));
        if (hit >= 0) begin
            check("hit_idx", 32'(hit_idx), 32'(hit));
        end else begin
            ph = nh;
            pv = nv;
        end
        check("player_hPos", 32'(player_hPos), 32'(ph));
        check("player_vPos", 32'(player_vPos), 32'(pv));
        @(posedge btnClk); #1;
        check("busy_released", 32'(busy), 0);
        check("pulse_one_cycle", 32'(move_done || blocked), 0);
    endtask

    task automatic mv(input logic [3:0] b, input logic [3:0] col);
        do_move(b, col, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt, nh, nv, s, c;
        logic [3:0] b;
        repeat (2) @(posedge btnClk);
        #1;
        do_reset();
        check("rst_hPos", 32'(player_hPos), 314);
        check("rst_vPos", 32'(player_vPos), 234);
        check("rst_busy", 32'(busy), 0);
        check("rst_move_done", 32'(move_done), 0);
        check("rst_blocked", 32'(blocked), 0);
        check("rst_hit_idx", 32'(hit_idx), 0);

        mv(4'd8, 4'd5);
        check("up_to_233", 32'(player_vPos), 233);

        do_reset();
        write_cfg(3, 300, 246, 40, 10, 2, 1);
        mv(4'd4, 4'd5);
        check("slot3_blocks", 32'(hit_idx), 3);
        mv(4'd4, 4'd2);
        check("same_colour_passes", 32'(player_vPos), 235);

        mv(4'b1010, 4'd5);
        mv(4'b0000, 4'd5);

        do_reset();
        do_move(4'd1, 4'd5, 1, 2, 6, 300, 230, 20, 20, 1, 1);
        do_reset();
        do_move(4'd1, 4'd5, 1, 2, 0, 300, 230, 20, 20, 1, 1);
        mv(4'd1, 4'd5);

        do_reset();
        cnt = 0;
        btns = 4'd2; player_color = 4'd3;
        for (int k = 0; k < 20; k++) begin
            @(posedge btnClk); #1;
            if (move_done) cnt++;
        end
        btns = '0;
        repeat (12) @(posedge btnClk);
        #1;
        check("held_rate_pulses", 32'(cnt), 2);
        check("held_rate_hPos", 32'(player_hPos), 316);

        do_reset();
        write_cfg(0, 320, 230, 20, 20, 1, 1);
        btns = 4'd2; player_color = 4'd5;
        @(posedge btnClk); #1;
        btns = '0;
        repeat (4) @(posedge btnClk);
        #1;
        rst_n = 1'b0;
        @(posedge btnClk); #1;
        rst_n = 1'b1;
        check("midscan_rst_busy", 32'(busy), 0);
        check("midscan_rst_hPos", 32'(player_hPos), 314);
        check("midscan_rst_vPos", 32'(player_vPos), 234);
        do_reset();
        mv(4'd2, 4'd5);
        check("table_cleared", 32'(player_hPos), 315);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(2)) begin
                s = int'($urandom_range(7));
                write_cfg(s, ph + int'($urandom_range(60)) - 40 < 0 ? 0 : ph + int'($urandom_range(60)) - 40,
                          pv + int'($urandom_range(60)) - 40 < 0 ? 0 : pv + int'($urandom_range(60)) - 40,
                          int'($urandom_range(40)), int'($urandom_range(40)),
                          int'($urandom_range(3)), bit'($urandom_range(4) != 0));
            end
            c = int'($urandom_range(3));
            case ($urandom_range(9))
                0: b = 4'($urandom_range(15));
                1, 2: b = 4'd8;
                3, 4: b = 4'd4;
                5, 6: b = 4'd2;
                default: b = 4'd1;
            endcase
            if ($urandom_range(3) == 0 && one_hot_dir(b))
                do_move(b, 4'(c), 1, int'($urandom_range(7)), int'($urandom_range(7)),
                        ph - 5, pv - 5, 22, 22, (c + 1) % 4, 1);
            else
                mv(b, 4'(c));
        end

        do_reset();
        for (int n = 0; n < 314; n++) mv(4'd1, 4'd0);
        check("reach_left_edge", 32'(player_hPos), 0);
        mv(4'd1, 4'd0);
        check("left_wrap", 32'(player_hPos), 628);
        for (int n = 0; n < 234; n++) mv(4'd4, 4'd0);
        check("reach_bottom", 32'(player_vPos), 468);
        mv(4'd4, 4'd0);
        check("down_wrap", 32'(player_vPos), 0);
        model_step(4'd8, ph, pv, nh, nv);
        mv(4'd8, 4'd0);
        check("up_wrap", 32'(player_vPos), 32'(nv));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
